// File: rtl/inv_key_expansion.sv
// Inverse AES-128 key schedule: accepts the round-10 key and streams round keys 10..0 over a
// valid/ready handshake, deriving each previous key from the current one.
// Optional feature macro: INV_KEY_EQ_MIXCOL_EN adds o_eqkey (InvMixColumns of rounds 1..9).
module inv_key_expansion #(
  parameter int unsigned NR = 10
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic [127:0] i_lastkey,
  output logic [127:0] o_roundkey,
  output logic [3:0]   o_round,
  output logic         o_key_valid,
  input  logic         i_key_ready,
  output logic         o_busy,
`ifdef INV_KEY_EQ_MIXCOL_EN
  output logic [127:0] o_eqkey,
`endif
  output logic         o_done
);

  localparam logic [3:0] LastRound = 4'(NR);

  typedef enum logic [1:0] {StIdle, StEmit, StSub, StStep} state_e;

  state_e         r_state, w_state_next;
  logic [127:0]   r_roundkey, w_roundkey_next;
  logic [3:0]     r_round, w_round_next;
  logic           r_key_valid, w_key_valid_next;
  logic           r_busy, w_busy_next;
  logic           r_done, w_done_next;
  logic [31:0]    r_sub;

  logic [31:0]    w_a, w_b, w_c, w_d;
  logic [31:0]    w_p0, w_p1, w_p2, w_p3;
  logic [31:0]    w_sub_in;
  logic [127:0]   w_prev_key;
  logic [3:0]     w_prev_round;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = '0;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // S-box as multiplicative inverse (a^254, so 0 maps to 0) followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x2, x3, x12, x15, x240, x252, inv;
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x252 = gf_mul(x240, x12);
    inv  = gf_mul(x252, x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] rcon(input logic [3:0] r);
    logic [7:0] rc;
    unique case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return {rc, 24'h0};
  endfunction

  assign w_a = r_roundkey[127:96];
  assign w_b = r_roundkey[95:64];
  assign w_c = r_roundkey[63:32];
  assign w_d = r_roundkey[31:0];

  assign w_p3 = w_d ^ w_c;
  assign w_p2 = w_c ^ w_b;
  assign w_p1 = w_b ^ w_a;
  // SubWord input is RotWord of the previous key's last word, which is already known as p3
  assign w_sub_in = {w_p3[23:0], w_p3[31:24]};
  assign w_p0 = w_a ^ r_sub ^ rcon(r_round);
  assign w_prev_key = {w_p0, w_p1, w_p2, w_p3};
  assign w_prev_round = 4'(r_round - 4'd1);

  // Four registered S-box lanes (one-cycle latency); contents need no reset
  always_ff @(posedge i_clk) begin
    r_sub <= {sbox(w_sub_in[31:24]), sbox(w_sub_in[23:16]), sbox(w_sub_in[15:8]),
              sbox(w_sub_in[7:0])};
  end

  // Next-state and next-output decode for the walk-back sequencer
  always_comb begin
    w_state_next     = r_state;
    w_roundkey_next  = r_roundkey;
    w_round_next     = r_round;
    w_key_valid_next = r_key_valid;
    w_busy_next      = r_busy;
    w_done_next      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_roundkey_next  = i_lastkey;
          w_round_next     = LastRound;
          w_key_valid_next = 1'b1;
          w_busy_next      = 1'b1;
          w_state_next     = StEmit;
        end
      end
      StEmit: begin
        if (i_key_ready) begin
          w_key_valid_next = 1'b0;
          if (r_round == 4'd0) begin
            w_busy_next  = 1'b0;
            w_done_next  = 1'b1;
            w_state_next = StIdle;
          end else begin
            w_state_next = StSub;
          end
        end
      end
      StSub: begin
        w_state_next = StStep;
      end
      StStep: begin
        w_roundkey_next  = w_prev_key;
        w_round_next     = w_prev_round;
        w_key_valid_next = 1'b1;
        w_state_next     = StEmit;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_roundkey  <= '0;
      r_round     <= '0;
      r_key_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_roundkey  <= w_roundkey_next;
      r_round     <= w_round_next;
      r_key_valid <= w_key_valid_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
    end
  end

  assign o_roundkey  = r_roundkey;
  assign o_round     = r_round;
  assign o_key_valid = r_key_valid;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

`ifdef INV_KEY_EQ_MIXCOL_EN
  logic [127:0] r_eqkey;

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] s0, s1, s2, s3;
    s0 = col[31:24];
    s1 = col[23:16];
    s2 = col[15:8];
    s3 = col[7:0];
    return {gf_mul(s0, 8'h0e) ^ gf_mul(s1, 8'h0b) ^ gf_mul(s2, 8'h0d) ^ gf_mul(s3, 8'h09),
            gf_mul(s0, 8'h09) ^ gf_mul(s1, 8'h0e) ^ gf_mul(s2, 8'h0b) ^ gf_mul(s3, 8'h0d),
            gf_mul(s0, 8'h0d) ^ gf_mul(s1, 8'h09) ^ gf_mul(s2, 8'h0e) ^ gf_mul(s3, 8'h0b),
            gf_mul(s0, 8'h0b) ^ gf_mul(s1, 8'h0d) ^ gf_mul(s2, 8'h09) ^ gf_mul(s3, 8'h0e)};
  endfunction

  // Equivalent-inverse-cipher key, loaded in lockstep with the round key
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_eqkey <= '0;
    end else if (r_state == StIdle && i_start) begin
      r_eqkey <= i_lastkey;
    end else if (r_state == StStep) begin
      // Round 0 passes through unmixed
      r_eqkey <= (w_prev_round == 4'd0) ? w_prev_key :
                 {inv_mix_col(w_prev_key[127:96]), inv_mix_col(w_prev_key[95:64]),
                  inv_mix_col(w_prev_key[63:32]), inv_mix_col(w_prev_key[31:0])};
    end
  end

  assign o_eqkey = r_eqkey;
`endif

endmodule

// File: tb/tb_inv_key_expansion.sv
// Bench for inv_key_expansion: word-level key-schedule model plus a cycle timing model,
// checked every cycle, with FIPS-197 A.1 literals and directed/random scenarios.
module tb_inv_key_expansion;

  localparam logic [127:0] A1Last = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] A1R9   = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] A1R1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1R0   = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         ready;
  logic [127:0] lastkey;
  logic [127:0] roundkey;
  logic [3:0]   round;
  logic         key_valid;
  logic         busy;
  logic         done;
`ifdef INV_KEY_EQ_MIXCOL_EN
  logic [127:0] eqkey;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int dut_keys = 0;
  bit chk_en = 1'b0;

  logic [7:0] sbox_t [256];

  inv_key_expansion u_dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_start     (start),
    .i_lastkey   (lastkey),
    .o_roundkey  (roundkey),
    .o_round     (round),
    .o_key_valid (key_valid),
    .i_key_ready (ready),
    .o_busy      (busy),
`ifdef INV_KEY_EQ_MIXCOL_EN
    .o_eqkey     (eqkey),
`endif
    .o_done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul(input logic [7:0] a, input int k);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  function automatic logic [31:0] imc(input logic [31:0] c);
    logic [7:0] s [4];
    logic [7:0] o [4];
    int m [4] = '{14, 11, 13, 9};
    for (int i = 0; i < 4; i++) s[i] = c[31-8*i -: 8];
    for (int r = 0; r < 4; r++) begin
      o[r] = 0;
      for (int j = 0; j < 4; j++) o[r] = o[r] ^ mul(s[j], m[(j - r + 4) % 4]);
    end
    return {o[0], o[1], o[2], o[3]};
  endfunction

  function automatic logic [127:0] imc128(input logic [127:0] k);
    return {imc(k[127:96]), imc(k[95:64]), imc(k[63:32]), imc(k[31:0])};
  endfunction

  function automatic logic [7:0] rcon_t(input int i);
    logic [7:0] rc;
    rc = 8'h01;
    for (int k = 1; k < i; k++) rc = xtime(rc);
    return rc;
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] t);
    logic [31:0] r;
    r = {t[23:0], t[31:24]};
    return {sbox_t[r[31:24]], sbox_t[r[23:16]], sbox_t[r[15:8]], sbox_t[r[7:0]]};
  endfunction

  // Recover the whole 44-word schedule backwards from the last four words
  function automatic logic [127:0] key_of(input logic [127:0] lk, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[40+i] = lk[127-32*i -: 32];
    for (int i = 39; i >= 0; i--) begin
      t = w[i+3];
      if (i % 4 == 0) t = sub_rot(t) ^ {rcon_t(i / 4 + 1), 24'h0};
      w[i] = w[i+4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // Standard forward expansion, used to cross-check the backward model
  function automatic logic [127:0] fwd_last(input logic [127:0] k0);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k0[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = sub_rot(t) ^ {rcon_t(i / 4), 24'h0};
      w[i] = w[i-4] ^ t;
    end
    return {w[40], w[41], w[42], w[43]};
  endfunction

  // Cycle timing model: key valid after start, 3-cycle gap after each accepted key
  logic         m_busy, m_valid, m_done;
  int           m_round, m_gap;
  logic [127:0] m_lk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 0; m_valid <= 0; m_done <= 0; m_round <= 0; m_gap <= 0; m_lk <= 0;
    end else begin
      m_done <= 0;
      if (!m_busy) begin
        if (start) begin
          m_lk <= lastkey; m_busy <= 1; m_valid <= 1; m_round <= 10;
        end
      end else if (m_valid) begin
        if (ready) begin
          m_valid <= 0;
          if (m_round == 0) begin
            m_busy <= 0; m_done <= 1;
          end else begin
            m_gap <= 2;
          end
        end
      end else if (m_gap == 2) begin
        m_gap <= 1;
      end else if (m_gap == 1) begin
        m_gap <= 0; m_valid <= 1; m_round <= m_round - 1;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && key_valid && ready) dut_keys <= dut_keys + 1;
  end

  // Compare DUT against the model every cycle
  always @(negedge clk) begin
    logic [127:0] exp;
    if (chk_en) begin
      chk("key_valid", 128'(key_valid), 128'(m_valid));
      chk("busy", 128'(busy), 128'(m_busy));
      chk("done", 128'(done), 128'(m_done));
      if (m_valid) begin
        exp = key_of(m_lk, m_round);
        chk("roundkey", roundkey, exp);
        chk("round", 128'(round), 128'(m_round));
`ifdef INV_KEY_EQ_MIXCOL_EN
        chk("eqkey", eqkey, (m_round == 0 || m_round == 10) ? exp : imc128(exp));
`endif
        if (m_lk == A1Last && m_round == 9) chk("a1_round9", roundkey, A1R9);
        if (m_lk == A1Last && m_round == 1) chk("a1_round1", roundkey, A1R1);
        if (m_lk == A1Last && m_round == 0) chk("a1_round0", roundkey, A1R0);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic fire(input logic [127:0] k);
    start = 1'b1;
    lastkey = k;
    step();
    start = 1'b0;
  endtask

  task automatic wait_round(input int r);
    bit ok;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      step();
      if (key_valid && round == 4'(r)) ok = 1;
    end
    if (!ok) chk("wait_round_timeout", 128'(0), 128'(r + 1));
  endtask

  task automatic wait_done();
    bit ok;
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      step();
      if (done) ok = 1;
    end
    if (!ok) chk("wait_done_timeout", 128'(0), 128'(1));
  endtask

  initial begin
    logic [7:0] p, q, x;
    logic [127:0] rk;
    int k0;
    rst = 1'b1; start = 1'b0; ready = 1'b1; lastkey = '0;

    // S-box table from the generator/inverse walk over GF(2^8)
    p = 8'h01; q = 8'h01;
    do begin
      p = p ^ xtime(p);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
    chk_en = 1'b1;

    // Model pins
    chk("sbox_53", 128'(sbox_t[8'h53]), 128'h ed);
    chk("sbox_01", 128'(sbox_t[8'h01]), 128'h7c);
    chk("model_a1_r0", key_of(A1Last, 0), A1R0);
    chk("model_imc", 128'(imc(32'h8e4da1bc)), 128'hdb135345);
    for (int i = 0; i < 3; i++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      chk("model_fwd_roundtrip", fwd_last(key_of(rk, 0)), rk);
    end

    // Reset state
    repeat (3) step();
    chk("rst_roundkey", roundkey, 128'h0);
    chk("rst_round", 128'(round), 128'h0);
    chk("rst_outs", 128'({key_valid, busy, done}), 128'h0);
    rst = 1'b0;
    step();

    // A.1 with ready held high: literal timing of valid/busy/done
    start = 1'b1; lastkey = A1Last;
    for (k0 = 1; k0 <= 33; k0++) begin
      step();
      start = 1'b0;
      lastkey = {$urandom, $urandom, $urandom, $urandom};
      chk("tm_valid", 128'(key_valid), 128'((k0 % 3 == 1) && k0 <= 31));
      chk("tm_busy", 128'(busy), 128'(k0 <= 31));
      chk("tm_done", 128'(done), 128'(k0 == 32));
    end
    chk("key_count", 128'(dut_keys), 128'd11);

    // Backpressure at round 7
    fire(A1Last);
    wait_round(7);
    ready = 1'b0;
    repeat (5) step();
    ready = 1'b1;
    wait_done();

    // Start while busy at round 5 is ignored; start after done runs a full sequence
    step();
    fire(A1Last);
    wait_round(5);
    fire(~A1Last);
    wait_done();
    step();
    k0 = dut_keys;
    fire(~A1Last);
    wait_done();
    chk("restart_key_count", 128'(dut_keys - k0), 128'd11);

    // Async reset mid-sequence at round 4
    step();
    fire(A1Last);
    wait_round(4);
    rst = 1'b1;
    #1;
    chk("midrst_roundkey", roundkey, 128'h0);
    chk("midrst_outs", 128'({round, key_valid, busy, done}), 128'h0);
    step();
    rst = 1'b0;
    step();
    fire(A1Last);
    chk("after_rst_round", 128'({key_valid, round}), 128'h1a);
    wait_done();

    // Random keys, random backpressure, spurious starts and lastkey churn
    for (int s = 0; s < 6; s++) begin
      bit fin;
      step();
      fire({$urandom, $urandom, $urandom, $urandom});
      fin = 0;
      for (int i = 0; i < 400 && !fin; i++) begin
        ready = ($urandom_range(0, 3) != 0);
        start = ($urandom_range(0, 7) == 0);
        lastkey = {$urandom, $urandom, $urandom, $urandom};
        step();
        start = 1'b0;
        if (done) fin = 1;
      end
      if (!fin) chk("rand_done_timeout", 128'(0), 128'(1));
      ready = 1'b1;
    end

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
